instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder_pkg.sv | 127 ++++++++++++
 rtl/instruction_encoder_if.sv | 40 ++++
 rtl/instruction_encoder_sync_fifo2.sv | 67 ++++++
 rtl/instruction_encoder.sv | 103 ++++++++++
 tb/tb_instruction_encoder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instruction_encoder_pkg
// Shared definitions for the instruction encoder and its matching decoder:
// request-kind encoding, opcode / funct / ALU code constants, the request and
// result structs, and the combinational encode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package instruction_encoder_pkg;

  // in_kind encoding
  typedef enum logic [1:0] {
    KIND_IMM   = 2'b00,
    KIND_SHIFT = 2'b01,
    KIND_ARITH = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_IMM    = 6'b111111;

  // Funct field values
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  // ALU operation codes
  localparam logic [3:0] ALU_SLL   = 4'b1100;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  alu;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic [4:0]  rsrc2;
    logic [4:0]  shamt;
    logic [20:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] instr;
  } enc_result_t;

  // Build an R-type word from its fields.
  function automatic logic [31:0] rtype_word(
    input logic [4:0] rdst,
    input logic [4:0] rsrc1,
    input logic [4:0] rsrc2,
    input logic [4:0] shamt,
    input logic [5:0] funct
  );
    rtype_word = {OP_RTYPE, rdst, rsrc1, rsrc2, shamt, funct};
  endfunction

  // Encode one request. An illegal request returns legal=0 and a zero word.
  // Immediate requests carry no ALU operation, so their alu code is ignored.
  function automatic enc_result_t encode(input enc_req_t req);
    enc_result_t res;
    res.legal = 1'b0;
    res.instr = 32'h0000_0000;
    case (kind_e'(req.kind))
      KIND_IMM: begin
        res.legal = 1'b1;
        res.instr = {OP_IMM, req.rdst, req.imm};
      end
      KIND_SHIFT: begin
        case (req.alu)
          ALU_SLL: begin
            res.legal = 1'b1;
            res.instr = rtype_word(req.rdst, req.rsrc1, req.rsrc2, req.shamt, FUNCT_SLL);
          end
          ALU_SRL: begin
            res.legal = 1'b1;
            res.instr = rtype_word(req.rdst, req.rsrc1, req.rsrc2, req.shamt, FUNCT_SRL);
          end
          default: begin
            res.legal = 1'b0;
            res.instr = 32'h0000_0000;
          end
        endcase
      end
      KIND_ARITH: begin
        // Arithmetic words always carry a zero shift amount.
        case (req.alu)
          ALU_ADD: begin
            res.legal = 1'b1;
            res.instr = rtype_word(req.rdst, req.rsrc1, req.rsrc2, 5'd0, FUNCT_ADD);
          end
          ALU_SUB: begin
            res.legal = 1'b1;
            res.instr = rtype_word(req.rdst, req.rsrc1, req.rsrc2, 5'd0, FUNCT_SUB);
          end
          ALU_AND: begin
            res.legal = 1'b1;
            res.instr = rtype_word(req.rdst, req.rsrc1, req.rsrc2, 5'd0, FUNCT_AND);
          end
          ALU_OR: begin
            res.legal = 1'b1;
            res.instr = rtype_word(req.rdst, req.rsrc1, req.rsrc2, 5'd0, FUNCT_OR);
          end
          default: begin
            res.legal = 1'b0;
            res.instr = 32'h0000_0000;
          end
        endcase
      end
      default: begin
        res.legal = 1'b0;
        res.instr = 32'h0000_0000;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// -----------------------------------------------------------------------------
// instruction_encoder_if
// Request / result bundle of the instruction encoder.
//   in_*      : encode request from the producer (valid/ready handshake)
//   out_*     : encoded word plus its instruction-memory address (valid/ready)
//   err       : one-cycle pulse after an illegal request was consumed
//   err_count : saturating count of illegal requests
// Modports: master = producer/consumer side, slave = encoder.
// -----------------------------------------------------------------------------
interface instruction_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [3:0]  in_alu_code;
  logic [4:0]  in_rdst;
  logic [4:0]  in_rsrc1;
  logic [4:0]  in_rsrc2;
  logic [4:0]  in_shamt;
  logic [20:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, in_kind, in_alu_code, in_rdst, in_rsrc1, in_rsrc2,
           in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport slave (
    input  in_valid, in_kind, in_alu_code, in_rdst, in_rsrc1, in_rsrc2,
           in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_count
  );

endinterface

// File: rtl/instruction_encoder_sync_fifo2.sv
// -----------------------------------------------------------------------------
// sync_fifo2
// Two-entry, 32-bit synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst          : clock, async active-high reset
//   i_push, i_data    : write request and data (ignored while full)
//   o_full            : both entries occupied
//   i_pop             : read request (ignored while empty)
//   o_valid, o_data   : head entry present / head data (straight from storage)
// -----------------------------------------------------------------------------
module sync_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [31:0] i_data,
  output logic        o_full,
  input  logic        i_pop,
  output logic        o_valid,
  output logic [31:0] o_data
);

  logic [1:0][31:0] r_mem;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // Qualify requests against occupancy.
  always_comb begin
    w_push = i_push && (r_count != 2'd2);
    w_pop  = i_pop  && (r_count != 2'd0);
  end

  // Storage, pointers and occupancy. Storage is cleared too so the head
  // reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status and head outputs.
  always_comb begin
    o_full  = (r_count == 2'd2);
    o_valid = (r_count != 2'd0);
    o_data  = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Encodes immediate / shift / arithmetic requests into 32-bit instruction
// words, buffers legal words in a 2-entry FIFO and hands them out together with
// an incrementing instruction-memory write address. Illegal requests are
// consumed, dropped, flagged with a one-cycle err pulse and counted.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : instruction_encoder_if.slave (request, result, error signals)
// -----------------------------------------------------------------------------
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  instruction_encoder_if.slave  bus
);

  enc_req_t    w_req;
  enc_result_t w_enc;
  logic        w_full;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_push;
  logic        w_bad;
  logic        w_fifo_valid;
  logic [31:0] w_fifo_data;
  logic        w_pop;
  logic [7:0]  r_addr;
  logic        r_err;
  logic [7:0]  r_err_count;

  // Combinational encode of the presented request.
  always_comb begin
    w_req.kind  = bus.in_kind;
    w_req.alu   = bus.in_alu_code;
    w_req.rdst  = bus.in_rdst;
    w_req.rsrc1 = bus.in_rsrc1;
    w_req.rsrc2 = bus.in_rsrc2;
    w_req.shamt = bus.in_shamt;
    w_req.imm   = bus.in_imm;
    w_enc       = encode(w_req);
  end

  // Handshake: any request (legal or not) is accepted only while the FIFO has
  // room, so an illegal request behind a full FIFO waits like a legal one.
  always_comb begin
    w_in_ready = !w_full;
    w_accept   = bus.in_valid && w_in_ready;
    w_push     = w_accept && w_enc.legal;
    w_bad      = w_accept && !w_enc.legal;
    w_pop      = bus.out_ready && w_fifo_valid;
  end

  sync_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_enc.instr),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data)
  );

  // Write address advances once per word handed to the consumer, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= 8'd0;
    end else if (w_pop) begin
      r_addr <= r_addr + 8'd1;
    end else begin
      r_addr <= r_addr;
    end
  end

  // Illegal-request pulse and saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_err <= w_bad;
      if (w_bad && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end else begin
        r_err_count <= r_err_count;
      end
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_fifo_valid;
    bus.out_instr = w_fifo_data;
    bus.out_addr  = r_addr;
    bus.err       = r_err;
    bus.err_count = r_err_count;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder
// Directed, table-driven bench for instruction_encoder plus hand-written
// sequences for backpressure, reset, error saturation and address wrap.
// -----------------------------------------------------------------------------
module tb_instruction_encoder;

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  alu;
    logic [4:0]  rdst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic [20:0] imm;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  localparam int NVEC = 12;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [7:0] exp_addr;
  logic [7:0] exp_err;
  vec_t vecs [NVEC];

  instruction_encoder_if bus ();

  instruction_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [1:0] kind, input logic [3:0] alu,
                              input logic [4:0] rdst, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] shamt,
                              input logic [20:0] imm, input logic legal,
                              input logic [31:0] instr);
    vec_t v;
    v.kind = kind; v.alu = alu; v.rdst = rdst; v.rs1 = rs1; v.rs2 = rs2;
    v.shamt = shamt; v.imm = imm; v.legal = legal; v.instr = instr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_kind     = v.kind;
    bus.in_alu_code = v.alu;
    bus.in_rdst     = v.rdst;
    bus.in_rsrc1    = v.rs1;
    bus.in_rsrc2    = v.rs2;
    bus.in_shamt    = v.shamt;
    bus.in_imm      = v.imm;
    bus.in_valid    = 1'b1;
  endtask

  task automatic imm_req(input logic [4:0] rdst, input logic [20:0] imm);
    drive(mk(2'b00, 4'b0000, rdst, 5'd0, 5'd0, 5'd0, imm, 1'b1, 32'h0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_addr = 8'd0;
    exp_err  = 8'd0;

    //         kind   alu      rdst   rs1    rs2    shamt  imm         legal  instr
    vecs[0]  = mk(2'b00, 4'b0000, 5'd3,  5'd0,  5'd0,  5'd0,  21'h00ABC,  1'b1, 32'hFC600ABC);
    vecs[1]  = mk(2'b10, 4'b0010, 5'd1,  5'd2,  5'd3,  5'd0,  21'h0,      1'b1, 32'h00221820);
    vecs[2]  = mk(2'b01, 4'b0011, 5'd4,  5'd5,  5'd0,  5'd2,  21'h0,      1'b1, 32'h00850082);
    vecs[3]  = mk(2'b01, 4'b1100, 5'd31, 5'd1,  5'd2,  5'd31, 21'h0,      1'b1, 32'h03E117C0);
    vecs[4]  = mk(2'b10, 4'b1000, 5'd2,  5'd3,  5'd4,  5'd7,  21'h0,      1'b1, 32'h00432022);
    vecs[5]  = mk(2'b10, 4'b0000, 5'd0,  5'd0,  5'd31, 5'd0,  21'h0,      1'b1, 32'h0000F824);
    vecs[6]  = mk(2'b10, 4'b0001, 5'd5,  5'd6,  5'd7,  5'd0,  21'h0,      1'b1, 32'h00A63825);
    vecs[7]  = mk(2'b10, 4'b1111, 5'd1,  5'd1,  5'd1,  5'd0,  21'h0,      1'b0, 32'h0);
    vecs[8]  = mk(2'b11, 4'b0010, 5'd1,  5'd1,  5'd1,  5'd0,  21'h0,      1'b0, 32'h0);
    vecs[9]  = mk(2'b01, 4'b0010, 5'd1,  5'd1,  5'd1,  5'd1,  21'h0,      1'b0, 32'h0);
    vecs[10] = mk(2'b00, 4'b0000, 5'd31, 5'd0,  5'd0,  5'd0,  21'h1FFFFF, 1'b1, 32'hFFFFFFFF);
    vecs[11] = mk(2'b10, 4'b0011, 5'd1,  5'd1,  5'd1,  5'd0,  21'h0,      1'b0, 32'h0);

    bus.in_valid = 1'b0;
    bus.in_kind = 2'b00; bus.in_alu_code = 4'b0000; bus.in_rdst = 5'd0;
    bus.in_rsrc1 = 5'd0; bus.in_rsrc2 = 5'd0; bus.in_shamt = 5'd0; bus.in_imm = 21'h0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr",  {24'd0, bus.out_addr},  32'd0);
    check("rst_err",       {31'd0, bus.err},       32'd0);
    check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    #22;
    rst = 1'b0;
    tick();

    // Table: one request, check one cycle later, then let it drain.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      check("tbl_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      if (vecs[i].legal) begin
        check("tbl_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("tbl_out_instr", bus.out_instr, vecs[i].instr);
        check("tbl_out_addr",  {24'd0, bus.out_addr}, {24'd0, exp_addr});
        check("tbl_err_low",   {31'd0, bus.err}, 32'd0);
        exp_addr = exp_addr + 8'd1;
      end else begin
        exp_err = exp_err + 8'd1;
        check("tbl_ill_no_valid", {31'd0, bus.out_valid}, 32'd0);
        check("tbl_ill_err",      {31'd0, bus.err}, 32'd1);
        check("tbl_ill_count",    {24'd0, bus.err_count}, {24'd0, exp_err});
      end
      tick();
      check("tbl_drained", {31'd0, bus.out_valid}, 32'd0);
      check("tbl_err_pulse_end", {31'd0, bus.err}, 32'd0);
      check("tbl_addr_after", {24'd0, bus.out_addr}, {24'd0, exp_addr});
    end

    // Empty FIFO: out_ready does not move the address.
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("empty_addr_hold", {24'd0, bus.out_addr}, {24'd0, exp_addr});

    // Backpressure: three requests with consumer stalled.
    bus.out_ready = 1'b0;
    imm_req(5'd1, 21'h0000A1);
    tick();
    imm_req(5'd2, 21'h0000B2);
    check("bp_ready_second", {31'd0, bus.in_ready}, 32'd1);
    tick();
    imm_req(5'd3, 21'h0000C3);
    check("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
    check("bp_head_held",  bus.out_instr, 32'hFC2000A1);
    check("bp_addr_held",  {24'd0, bus.out_addr}, {24'd0, exp_addr});
    bus.out_ready = 1'b1;
    tick();
    // A popped; C could not enter on that edge.
    exp_addr = exp_addr + 8'd1;
    check("bp_head_b",  bus.out_instr, 32'hFC4000B2);
    check("bp_addr_b",  {24'd0, bus.out_addr}, {24'd0, exp_addr});
    check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    // C pushed while B popped: occupancy stays one.
    bus.in_valid = 1'b0;
    exp_addr = exp_addr + 8'd1;
    check("bp_head_c",  bus.out_instr, 32'hFC6000C3);
    check("bp_valid_c", {31'd0, bus.out_valid}, 32'd1);
    check("bp_addr_c",  {24'd0, bus.out_addr}, {24'd0, exp_addr});
    tick();
    exp_addr = exp_addr + 8'd1;
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    check("bp_addr_end", {24'd0, bus.out_addr}, {24'd0, exp_addr});

    // Reset with two words buffered.
    bus.out_ready = 1'b0;
    imm_req(5'd7, 21'h000111);
    tick();
    imm_req(5'd8, 21'h000222);
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("mid_rst_out_addr",  {24'd0, bus.out_addr},  32'd0);
    check("mid_rst_out_instr", bus.out_instr, 32'd0);
    check("mid_rst_err_count", {24'd0, bus.err_count}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    imm_req(5'd9, 21'h000333);
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_instr", bus.out_instr, 32'hFD200333);
    check("post_rst_addr",  {24'd0, bus.out_addr}, 32'd0);
    tick();
    check("post_rst_drained", {31'd0, bus.out_valid}, 32'd0);

    // Error counter saturation: 256 back-to-back illegal requests.
    drive(vecs[7]);
    tick();
    check("sat_first_err",   {31'd0, bus.err}, 32'd1);
    check("sat_first_count", {24'd0, bus.err_count}, 32'd1);
    check("sat_no_valid",    {31'd0, bus.out_valid}, 32'd0);
    repeat (254) tick();
    check("sat_255_count",   {24'd0, bus.err_count}, 32'd255);
    tick();
    check("sat_256_count",   {24'd0, bus.err_count}, 32'd255);
    check("sat_256_err",     {31'd0, bus.err}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("sat_err_clear",   {31'd0, bus.err}, 32'd0);
    check("sat_hold_count",  {24'd0, bus.err_count}, 32'd255);

    // Address wrap: 257 words from address 0.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    exp_addr = 8'd0;
    for (int i = 0; i < 257; i++) begin
      imm_req(i[4:0], i[20:0]);
      tick();
      bus.in_valid = 1'b0;
      check("wrap_addr",  {24'd0, bus.out_addr}, {24'd0, exp_addr});
      check("wrap_instr", bus.out_instr, {6'b111111, i[4:0], i[20:0]});
      tick();
      exp_addr = exp_addr + 8'd1;
    end
    check("wrap_final_addr", {24'd0, bus.out_addr}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
